// File: rtl/mux_arb_reg.sv
// mux_arb_reg: N:1 registered multiplexer with valid/ready handshake, fixed-select or round-robin.
// Optional MUX_LOCK_EN adds LAST_IN packet locking in round-robin mode.
module mux_arb_reg #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [CHANNELS*WIDTH-1:0] DIN,
  input  logic [CHANNELS-1:0]       VALID_IN,
`ifdef MUX_LOCK_EN
  input  logic [CHANNELS-1:0]       LAST_IN,
`endif
  output logic [CHANNELS-1:0]       ACK,
  input  logic                      MODE,
  input  logic [SEL_W-1:0]          SEL,
  input  logic                      READY_IN,
  output logic [WIDTH-1:0]          MUXOUT,
  output logic                      VALID_OUT,
  output logic [SEL_W-1:0]          CH_OUT
);

  logic [SEL_W-1:0] ptr;
  logic             can_load;
  logic             cand_ok;
  logic [SEL_W-1:0] cand;
  logic             grant;
  logic             advance;
  logic             hi_ok, lo_ok;
  logic [SEL_W-1:0] hi_ch, lo_ch;
  logic [WIDTH-1:0] grant_data;

`ifdef MUX_LOCK_EN
  logic             locked;
  logic [SEL_W-1:0] lock_ch;
  logic             grant_last;
`endif

  assign can_load = !VALID_OUT || READY_IN;

  // Wrap-around scan: lowest valid channel at or above ptr wins, otherwise lowest one below ptr.
  always_comb begin
    hi_ok = 1'b0;
    lo_ok = 1'b0;
    hi_ch = '0;
    lo_ch = '0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (VALID_IN[j]) begin
        if (SEL_W'(j) >= ptr) begin
          hi_ok = 1'b1;
          hi_ch = SEL_W'(j);
        end else begin
          lo_ok = 1'b1;
          lo_ch = SEL_W'(j);
        end
      end
    end
  end

  always_comb begin
    cand_ok = 1'b0;
    cand    = '0;
    if (!MODE) begin
      cand = SEL;
      for (int j = 0; j < CHANNELS; j++) begin
        if (SEL == SEL_W'(j)) cand_ok = VALID_IN[j];
      end
    end
`ifdef MUX_LOCK_EN
    else if (locked) begin
      cand = lock_ch;
      for (int j = 0; j < CHANNELS; j++) begin
        if (lock_ch == SEL_W'(j)) cand_ok = VALID_IN[j];
      end
    end
`endif
    else begin
      cand_ok = hi_ok || lo_ok;
      cand    = hi_ok ? hi_ch : lo_ch;
    end
  end

  assign grant = RST_N && cand_ok && can_load;

  always_comb begin
    ACK        = '0;
    grant_data = '0;
`ifdef MUX_LOCK_EN
    grant_last = 1'b0;
`endif
    for (int j = 0; j < CHANNELS; j++) begin
      if (cand == SEL_W'(j)) begin
        ACK[j]     = grant;
        grant_data = DIN[j*WIDTH +: WIDTH];
`ifdef MUX_LOCK_EN
        grant_last = LAST_IN[j];
`endif
      end
    end
  end

`ifdef MUX_LOCK_EN
  assign advance = grant && MODE && grant_last;
`else
  assign advance = grant && MODE;
`endif

  // VALID_OUT doubles as the EMPTY/FULL occupancy state; a grant while FULL replaces data with no bubble.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MUXOUT    <= '0;
      VALID_OUT <= 1'b0;
      CH_OUT    <= '0;
    end else if (grant) begin
      MUXOUT    <= grant_data;
      CH_OUT    <= cand;
      VALID_OUT <= 1'b1;
    end else if (READY_IN) begin
      VALID_OUT <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (cand == SEL_W'(CHANNELS - 1)) ? '0 : cand + 1'b1;
    end
  end

`ifdef MUX_LOCK_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (!MODE) begin
      locked <= 1'b0;
    end else if (grant) begin
      locked  <= !grant_last;
      lock_ch <= cand;
    end
  end
`endif

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb_mux_arb_reg: directed scenarios plus a randomized run checked against a behavioural model.
// Works with or without MUX_LOCK_EN defined.
`timescale 1ns/1ps
module tb_mux_arb_reg;
  localparam int W  = 8;
  localparam int C  = 4;
  localparam int SW = 2;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [C-1:0][W-1:0] din_p;
  logic [C-1:0]      valid_in;
  logic [C-1:0]      ack;
  logic              mode;
  logic [SW-1:0]     sel;
  logic              ready_in;
  logic [W-1:0]      muxout;
  logic              valid_out;
  logic [SW-1:0]     ch_out;

  logic [2:0][W-1:0] din3;
  logic [2:0]        valid3;
  logic [2:0]        ack3;
  logic [1:0]        sel3;
  logic [W-1:0]      muxout3;
  logic              valid_out3;
  logic [1:0]        ch_out3;

`ifdef MUX_LOCK_EN
  logic [C-1:0]      last_in;
  logic [2:0]        last3;
`endif

  int checks = 0;
  int fails  = 0;

  int         m_valid, m_ch, m_ptr, m_lock;
  logic [W-1:0] m_data;

  int seq4 [6] = '{0, 1, 2, 3, 0, 1};
  int seq6 [5];

  always #5 CLK = ~CLK;

  mux_arb_reg #(.WIDTH(W), .CHANNELS(C)) dut (
    .CLK(CLK), .RST_N(RST_N), .DIN(din_p), .VALID_IN(valid_in),
`ifdef MUX_LOCK_EN
    .LAST_IN(last_in),
`endif
    .ACK(ack), .MODE(mode), .SEL(sel), .READY_IN(ready_in),
    .MUXOUT(muxout), .VALID_OUT(valid_out), .CH_OUT(ch_out)
  );

  mux_arb_reg #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .DIN(din3), .VALID_IN(valid3),
`ifdef MUX_LOCK_EN
    .LAST_IN(last3),
`endif
    .ACK(ack3), .MODE(1'b0), .SEL(sel3), .READY_IN(1'b1),
    .MUXOUT(muxout3), .VALID_OUT(valid_out3), .CH_OUT(ch_out3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_valid = 0;
    m_data  = '0;
    m_ch    = 0;
    m_ptr   = 0;
    m_lock  = -1;
  endtask

  // Channel the rules say should be granted this cycle, or -1.
  function automatic int modelPick();
    int g;
    int c;
    g = -1;
    if (!RST_N) return -1;
    if (m_valid != 0 && !ready_in) return -1;
    if (!mode) begin
      if (int'(sel) < C && valid_in[sel]) g = int'(sel);
    end else if (m_lock >= 0) begin
      if (valid_in[m_lock[1:0]]) g = m_lock;
    end else begin
      for (int k = 0; k < C; k++) begin
        c = (m_ptr + k) % C;
        if (g < 0 && valid_in[c[1:0]]) g = c;
      end
    end
    return g;
  endfunction

  task automatic modelUpdate(input int g);
    if (g >= 0) begin
      m_data  = din_p[g[1:0]];
      m_ch    = g;
      m_valid = 1;
    end else if (ready_in) begin
      m_valid = 0;
    end
    if (!mode) begin
      m_lock = -1;
    end else if (g >= 0) begin
`ifdef MUX_LOCK_EN
      if (!last_in[g[1:0]]) m_lock = g;
      else begin
        m_lock = -1;
        m_ptr  = (g + 1) % C;
      end
`else
      m_ptr = (g + 1) % C;
`endif
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic applyStimulus(input string tag);
    int g;
    logic [C-1:0] exp_ack;
    #1;
    g = modelPick();
    exp_ack = '0;
    if (g >= 0) exp_ack[g[1:0]] = 1'b1;
    checkOutput({tag, ".ack"},   32'(ack),       32'(exp_ack));
    checkOutput({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    checkOutput({tag, ".data"},  32'(muxout),    32'(m_data));
    checkOutput({tag, ".ch"},    32'(ch_out),    32'(m_ch));
    modelUpdate(g);
    @(negedge CLK);
  endtask

  task automatic pulseReset();
    RST_N = 1'b0;
    #1;
    modelReset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    #1000000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST_N    = 1'b0;
    mode     = 1'b0;
    sel      = '0;
    ready_in = 1'b0;
    valid_in = 4'hF;
    din_p    = '0;
    din3     = '0;
    valid3   = '0;
    sel3     = '0;
`ifdef MUX_LOCK_EN
    last_in  = 4'hF;
    last3    = 3'h7;
    seq6     = '{0, 1, 1, 1, 2};
`else
    seq6     = '{0, 1, 2, 3, 0};
`endif
    modelReset();
    repeat (2) @(negedge CLK);
    #1;
    checkOutput("init.ack",   32'(ack),       32'h0);
    checkOutput("init.valid", 32'(valid_out), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Asynchronous reset while holding unconsumed data.
    mode = 1'b0; sel = 2'd0; din_p[0] = 8'h3C; valid_in = 4'b0001; ready_in = 1'b1;
    applyStimulus("load3c");
    valid_in = 4'b0000; ready_in = 1'b0;
    applyStimulus("hold3c");
    checkOutput("prereset.data", 32'(muxout), 32'h3C);
    valid_in = 4'hF; mode = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    modelReset();
    checkOutput("areset.data",  32'(muxout),    32'h0);
    checkOutput("areset.valid", 32'(valid_out), 32'h0);
    checkOutput("areset.ch",    32'(ch_out),    32'h0);
    checkOutput("areset.ack",   32'(ack),       32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    ready_in = 1'b1;
    applyStimulus("rr_first");
    checkOutput("rr_first.ch", 32'(ch_out), 32'h0);

    // Fixed select of channel 2.
    mode = 1'b0; sel = 2'd2; din_p = {8'h44, 8'hA5, 8'h22, 8'h11}; valid_in = 4'b0100;
    #1 checkOutput("fixed.ack_now", 32'(ack), 32'b0100);
    applyStimulus("fixed");
    checkOutput("fixed.data",  32'(muxout),    32'hA5);
    checkOutput("fixed.valid", 32'(valid_out), 32'h1);
    checkOutput("fixed.ch",    32'(ch_out),    32'h2);

    // Backpressure: nothing accepted, output held.
    mode = 1'b1; valid_in = 4'hF; ready_in = 1'b0;
    din_p = {8'h43, 8'h32, 8'h21, 8'h10};
    for (int i = 0; i < 5; i++) begin
      applyStimulus("stall");
      checkOutput("stall.data", 32'(muxout), 32'hA5);
    end
    ready_in = 1'b1;
    applyStimulus("release");
    checkOutput("release.ch",    32'(ch_out),    32'h1);
    checkOutput("release.data",  32'(muxout),    32'h21);
    checkOutput("release.valid", 32'(valid_out), 32'h1);

    // Round-robin with all channels valid.
    pulseReset();
    mode = 1'b1; valid_in = 4'hF; ready_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus("rr_all");
      checkOutput("rr_all.seq", 32'(ch_out), 32'(seq4[i]));
    end

    // Wrap from the top channel with only channels 0 and 1 requesting.
    pulseReset();
    valid_in = 4'b0100;
    applyStimulus("rr_to3");
    checkOutput("rr_to3.ch", 32'(ch_out), 32'h2);
    valid_in = 4'b0011;
    applyStimulus("rr_wrap0");
    checkOutput("rr_wrap0.ch", 32'(ch_out), 32'h0);
    applyStimulus("rr_wrap1");
    checkOutput("rr_wrap1.ch", 32'(ch_out), 32'h1);
    applyStimulus("rr_wrap2");
    checkOutput("rr_wrap2.ch", 32'(ch_out), 32'h0);

    // Three-channel instance: out-of-range select never grants.
    valid_in = '0;
    din3 = {8'h77, 8'h66, 8'h55}; valid3 = 3'b111; sel3 = 2'd3;
    #1 checkOutput("c3.sel3_ack", 32'(ack3), 32'h0);
    @(negedge CLK);
    checkOutput("c3.sel3_valid", 32'(valid_out3), 32'h0);
    sel3 = 2'd2;
    #1 checkOutput("c3.sel2_ack", 32'(ack3), 32'b100);
    @(negedge CLK);
    checkOutput("c3.sel2_data", 32'(muxout3), 32'h77);
    checkOutput("c3.sel2_ch",   32'(ch_out3), 32'h2);
    valid3 = '0;
    pulseReset();

    // Packet lock on channel 1 (plain round-robin without the lock feature).
    mode = 1'b1; valid_in = 4'hF; ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
`ifdef MUX_LOCK_EN
      last_in = (i < 3) ? 4'b1101 : 4'b1111;
`endif
      applyStimulus("lock");
      checkOutput("lock.seq", 32'(ch_out), 32'(seq6[i]));
    end

    // Randomized traffic against the model.
    pulseReset();
    for (int i = 0; i < 400; i++) begin
      mode     = ($urandom_range(0, 3) != 0);
      sel      = SW'($urandom_range(0, C - 1));
      valid_in = C'($urandom);
      ready_in = ($urandom_range(0, 3) != 0);
      din_p    = $urandom;
`ifdef MUX_LOCK_EN
      last_in  = C'($urandom) | C'($urandom);
`endif
      applyStimulus("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
